// File: rtl/video_sched_pkg.sv
// Shared definitions for the composite line scheduler: sequencer states, stage indices and the
// default number of rendered lines per field.
package video_sched_pkg;

  localparam int unsigned STAGE_L0            = 0;
  localparam int unsigned STAGE_L1            = 1;
  localparam int unsigned STAGE_SPR           = 2;
  localparam int unsigned NUM_STAGES          = 3;
  localparam int unsigned DEFAULT_FIELD_LINES = 240;

  typedef enum logic [2:0] {
    StIdle,
    StStart0,
    StWait0,
    StStart1,
    StWait1,
    StStart2,
    StWait2,
    StLineDone
  } sched_state_e;

endpackage

// File: rtl/composite_line_scheduler_if.sv
// Timing-generator strobes, renderer handshake and status outputs of the line scheduler.
// slave: the scheduler; master: whatever drives the strobes and observes the results.
interface composite_line_scheduler_if
  import video_sched_pkg::*;
#(
  parameter int unsigned LINE_W = 10
);
  logic                  next_frame;
  logic                  next_line;
  logic                  vblank_pulse;
  logic                  current_field;
  logic                  interlaced;
  logic [NUM_STAGES-1:0] layer_en;
  logic [NUM_STAGES-1:0] render_done;
  logic                  irq_ack;
  logic [NUM_STAGES-1:0] render_start;
  logic                  render_abort;
  logic [LINE_W-1:0]     render_line;
  logic                  line_buf_sel;
  logic                  busy;
  logic                  overrun;
  logic                  vblank_irq;

  modport master (
    output next_frame, next_line, vblank_pulse, current_field, interlaced, layer_en,
           render_done, irq_ack,
    input  render_start, render_abort, render_line, line_buf_sel, busy, overrun, vblank_irq
  );

  modport slave (
    input  next_frame, next_line, vblank_pulse, current_field, interlaced, layer_en,
           render_done, irq_ack,
    output render_start, render_abort, render_line, line_buf_sel, busy, overrun, vblank_irq
  );

endinterface

// File: rtl/scheduler_line_counter.sv
// Line index and remaining-line counter for one field; load restarts the field, step moves to
// the next rendered line (by two in interlaced mode).
module scheduler_line_counter
  import video_sched_pkg::*;
#(
  parameter int unsigned FIELD_LINES = DEFAULT_FIELD_LINES,
  parameter int unsigned LINE_W      = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              interlaced_i,
  input  logic              current_field_i,
  output logic [LINE_W-1:0] render_line_o,
  output logic              lines_left_nz_o
);

  localparam int unsigned CntW = (FIELD_LINES > 1) ? $clog2(FIELD_LINES) : 1;

  logic [LINE_W-1:0] render_line_q, render_line_d;
  logic [CntW-1:0]   lines_left_q, lines_left_d;

  always_comb begin
    render_line_d = render_line_q;
    lines_left_d  = lines_left_q;
    if (load_i) begin
      // Odd field starts on line 1 only when fields carry distinct lines.
      render_line_d = interlaced_i ? LINE_W'(current_field_i) : '0;
      lines_left_d  = CntW'(FIELD_LINES - 1);
    end else if (step_i) begin
      render_line_d = render_line_q + (interlaced_i ? LINE_W'(2) : LINE_W'(1));
      lines_left_d  = lines_left_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      render_line_q <= '0;
      lines_left_q  <= '0;
    end else begin
      render_line_q <= render_line_d;
      lines_left_q  <= lines_left_d;
    end
  end

  assign render_line_o   = render_line_q;
  assign lines_left_nz_o = (lines_left_q != '0);

endmodule

// File: rtl/composite_line_scheduler.sv
// Per-line render sequencer: walks layer0 -> layer1 -> sprites through a start/done handshake,
// swaps the double-buffered line store and flags lines that were not finished in time.
module composite_line_scheduler
  import video_sched_pkg::*;
#(
  parameter int unsigned FIELD_LINES = DEFAULT_FIELD_LINES,
  parameter int unsigned LINE_W      = 10
) (
  input logic                       clk,
  input logic                       rst,
  composite_line_scheduler_if.slave bus
);

  sched_state_e          state_q, state_d;
  logic                  buf_sel_q, buf_sel_d;
  logic                  irq_q, irq_d;
  logic                  lines_left_nz;
  logic                  load, step, busy, line_trig;
  logic                  abort, overrun;
  logic [NUM_STAGES-1:0] start;
  logic [LINE_W-1:0]     render_line;

  always_comb begin
    state_d   = state_q;
    buf_sel_d = buf_sel_q;
    start     = '0;
    abort     = 1'b0;
    overrun   = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    busy      = (state_q != StIdle) && (state_q != StLineDone);
    line_trig = bus.next_line && !bus.next_frame && (lines_left_nz || (state_q != StIdle));

    // A disabled stage spends its single START cycle without a pulse and moves on.
    case (state_q)
      StStart0: begin
        start[STAGE_L0] = bus.layer_en[STAGE_L0];
        state_d         = bus.layer_en[STAGE_L0] ? StWait0 : StStart1;
      end
      StWait0: if (bus.render_done[STAGE_L0]) state_d = StStart1;
      StStart1: begin
        start[STAGE_L1] = bus.layer_en[STAGE_L1];
        state_d         = bus.layer_en[STAGE_L1] ? StWait1 : StStart2;
      end
      StWait1: if (bus.render_done[STAGE_L1]) state_d = StStart2;
      StStart2: begin
        start[STAGE_SPR] = bus.layer_en[STAGE_SPR];
        state_d          = bus.layer_en[STAGE_SPR] ? StWait2 : StLineDone;
      end
      StWait2: if (bus.render_done[STAGE_SPR]) state_d = StLineDone;
      default: ;
    endcase

    // Line boundaries override the sequence; a start that would coincide with an abort is dropped.
    if (bus.next_frame) begin
      start   = '0;
      abort   = busy;
      load    = 1'b1;
      state_d = StStart0;
    end else if (line_trig) begin
      start     = '0;
      abort     = busy;
      overrun   = busy;
      buf_sel_d = ~buf_sel_q;
      if (lines_left_nz) begin
        step    = 1'b1;
        state_d = StStart0;
      end else begin
        state_d = StIdle;
      end
    end

    irq_d = bus.vblank_pulse ? 1'b1 : (bus.irq_ack ? 1'b0 : irq_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      buf_sel_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_sel_q <= buf_sel_d;
      irq_q     <= irq_d;
    end
  end

  scheduler_line_counter #(
    .FIELD_LINES (FIELD_LINES),
    .LINE_W      (LINE_W)
  ) u_line_counter (
    .clk             (clk),
    .rst             (rst),
    .load_i          (load),
    .step_i          (step),
    .interlaced_i    (bus.interlaced),
    .current_field_i (bus.current_field),
    .render_line_o   (render_line),
    .lines_left_nz_o (lines_left_nz)
  );

  assign bus.render_start = start;
  assign bus.render_abort = abort;
  assign bus.render_line  = render_line;
  assign bus.line_buf_sel = buf_sel_q;
  assign bus.busy         = busy;
  assign bus.overrun      = overrun;
  assign bus.vblank_irq   = irq_q;

endmodule
